blit_mem_responder: RTL

BLIT_MEM_RESPONDER -- requirements
Module: blit_mem_responder

---
 rtl/blit_mem_responder_pkg.sv | 19 +
 rtl/blit_mem_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/blit_mem_responder_pkg.sv
// Shared blitter definitions: responder FSM encoding,
// default burst length and downstream command constants.
package blit_mem_responder_pkg;

  localparam int BURST_WORDS_DEF = 4;

  localparam logic       CMD_READ  = 1'b0;
  localparam logic       CMD_WRITE = 1'b1;
  localparam logic [3:0] BE_ALL    = 4'hF;
  localparam logic [3:0] BE_NONE   = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_RD_CMD,
    ST_RD_DATA
  } state_t;

endpackage

// File: rtl/blit_mem_responder.sv
// Arbitrates blitter line reads and single-word writes onto one
// SDRAM command port; one transaction in flight at a time.
module blit_mem_responder
  import blit_mem_responder_pkg::*;
#(
  parameter int BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        blitw_request,
  input  logic [25:0] blitw_address,
  input  logic [31:0] blitw_wdata,
  input  logic [3:0]  blitw_byte_en,
  output logic        blitw_complete,
  input  logic        blitr_request,
  input  logic [25:0] blitr_address,
  output logic [31:0] blitr_rdata,
  output logic        blitr_valid,
  output logic        blitr_complete,
  output logic        sdram_request,
  output logic        sdram_write,
  output logic [25:0] sdram_address,
  output logic [31:0] sdram_wdata,
  output logic [3:0]  sdram_byte_en,
  input  logic        sdram_ready,
  input  logic [31:0] sdram_rdata,
  input  logic        sdram_rvalid
);

  localparam int CW = $clog2(BURST_WORDS);
  localparam logic [25:0] RD_MASK =
    ~(26'(BURST_WORDS * 4) - 26'd1);
  localparam logic [25:0] WR_MASK = ~26'h3;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_WORDS - 1);

  state_t r_state;
  state_t w_next;

  logic          r_last_rd;
  logic [CW-1:0] r_beat;
  logic          r_nocmd;
  logic          r_req;
  logic          r_wr;
  logic [25:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_rdata;
  logic          r_valid;
  logic          r_rcmpl;

  logic w_grant_wr;
  logic w_grant_rd;
  logic w_wr_done;
  logic w_rd_accept;
  logic w_beat;

  // An empty-lane write finishes without ever touching SDRAM.
  assign w_wr_done   = (r_state == ST_WR_CMD) &&
                       (r_nocmd || (r_req && sdram_ready));
  assign w_rd_accept = (r_state == ST_RD_CMD) &&
                       r_req && sdram_ready;
  assign w_beat      = (r_state == ST_RD_DATA) &&
                       sdram_rvalid && !r_rcmpl;

  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    w_next     = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (blitw_request && blitr_request) begin
          w_grant_wr = r_last_rd;
          w_grant_rd = !r_last_rd;
        end else begin
          w_grant_wr = blitw_request;
          w_grant_rd = blitr_request;
        end
        if (w_grant_wr)      w_next = ST_WR_CMD;
        else if (w_grant_rd) w_next = ST_RD_CMD;
      end
      ST_WR_CMD:  if (w_wr_done)   w_next = ST_IDLE;
      ST_RD_CMD:  if (w_rd_accept) w_next = ST_RD_DATA;
      // Stay here through the complete pulse so nothing is
      // granted in that cycle.
      ST_RD_DATA: if (r_rcmpl)     w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_last_rd <= 1'b1;
      r_beat    <= '0;
      r_nocmd   <= 1'b0;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_valid   <= 1'b0;
      r_rcmpl   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_beat;
      r_rcmpl <= w_beat && (r_beat == LAST_BEAT);
      if (w_beat) begin
        r_rdata <= sdram_rdata;
        r_beat  <= r_beat + CW'(1);
      end
      if (w_rd_accept) r_beat <= '0;
      if (w_grant_wr) begin
        r_last_rd <= 1'b0;
        r_wr      <= CMD_WRITE;
        r_addr    <= blitw_address & WR_MASK;
        r_wdata   <= blitw_wdata;
        r_be      <= blitw_byte_en;
        r_nocmd   <= (blitw_byte_en == BE_NONE);
        r_req     <= (blitw_byte_en != BE_NONE);
      end else if (w_grant_rd) begin
        r_last_rd <= 1'b1;
        r_wr      <= CMD_READ;
        r_addr    <= blitr_address & RD_MASK;
        r_wdata   <= '0;
        r_be      <= BE_ALL;
        r_nocmd   <= 1'b0;
        r_req     <= 1'b1;
      end else if (r_req && sdram_ready) begin
        r_req <= 1'b0;
      end
    end
  end

  assign blitw_complete = w_wr_done;
  assign sdram_request  = r_req;
  assign sdram_write    = r_wr;
  assign sdram_address  = r_addr;
  assign sdram_wdata    = r_wdata;
  assign sdram_byte_en  = r_be;
  assign blitr_rdata    = r_rdata;
  assign blitr_valid    = r_valid;
  assign blitr_complete = r_rcmpl;

endmodule
